// File: rtl/aes_inv_round_seq.sv
// aes_inv_round_seq: iterative AES inverse cipher, one round per clock.
// Ports: clk/rst (async, active-high), in_valid/in_ready/in_data
//   (ciphertext), rk_idx/rk_data (external key store lookup, same cycle),
//   out_valid/out_ready/out_data (plaintext, straight from state reg).
// Param NR: 10, 12 or 14 rounds.
// Optional: define AES_INV_ABORT_EN to add the abort input.
module aes_inv_round_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_INV_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_round_seq: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] LP_NR   = 4'(NR);
    localparam logic [3:0] LP_NRM1 = 4'(NR - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte (row r, col c) lives at index 4*c+r, byte 0 in [127:120].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                               gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                               gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                               gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                               gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [2:0]   r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_rnd;

    logic         w_abort;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

`ifdef AES_INV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Shared datapath: FINAL uses w_ark, ROUND adds InvMixColumns on top.
    assign w_ark = inv_sub_bytes(inv_shift_rows(r_state)) ^ rk_data;
    assign w_imc = inv_mix_columns(w_ark);

    assign in_ready  = (r_fsm == S_IDLE) && !rst && !w_abort;
    assign out_valid = (r_fsm == S_DONE);
    assign out_data  = r_state;

    always_comb begin
        rk_idx = 4'd0;
        case (r_fsm)
            S_INIT:  rk_idx = LP_NR;
            S_ROUND: rk_idx = r_rnd;
            default: rk_idx = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
        end else if (w_abort) begin
            // Abort wins over every handshake; state register is kept.
            r_fsm <= S_IDLE;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_fsm   <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_state <= r_state ^ rk_data;
                    r_rnd   <= LP_NRM1;
                    r_fsm   <= S_ROUND;
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    if (r_rnd == 4'd1) begin
                        r_fsm <= S_FINAL;
                    end else begin
                        r_rnd <= r_rnd - 4'd1;
                    end
                end
                S_FINAL: begin
                    r_state <= w_ark;
                    r_fsm   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) r_fsm <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// tb_aes_inv_round_seq: directed bench for aes_inv_round_seq (NR=10),
// FIPS-197 AES-128 key schedule and vector, handshake/reset/abort cases.
module tb_aes_inv_round_seq;

    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_INV_ABORT_EN
    logic         abort;
`endif

    logic [127:0] keys [16];
    int           n_checks = 0;
    int           n_errors = 0;

    assign rk_data = keys[rk_idx];

    always #5 clk = ~clk;

    aes_inv_round_seq #(.NR(10)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_INV_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue CT from IDLE, wait for the result, check latency/data, consume.
    task automatic do_block(input string tag);
        int n;
        n = 0;
        chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
        in_data  = CT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'd11);
        chk({tag, "_pt"}, out_data, PT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int gap;
        int m;
        keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 16; i++) keys[i] = '0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_INV_ABORT_EN
        abort     = 1'b0;
`endif

        // Reset state
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        #10;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'd1);
        tick();

        // FIPS-197 vector, rk_idx sequence, DONE hold with out_ready low
        in_data  = CT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        for (int j = 0; j <= 10; j++) begin
            chk($sformatf("rk_seq%0d", j), 128'(rk_idx),
                128'((j == 10) ? 0 : 10 - j));
            chk("early_valid", 128'(out_valid), 128'd0);
            tick();
        end
        chk("done_valid", 128'(out_valid), 128'd1);
        chk("done_pt", out_data, PT);
        chk("done_rk", 128'(rk_idx), 128'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_data", out_data, PT);
            chk("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid", 128'(out_valid), 128'd0);
        chk("hs_in_ready", 128'(in_ready), 128'd1);
        chk("hs_keep_data", out_data, PT);

        // Back-to-back with in_valid held high and out_ready tied high
        out_ready = 1'b1;
        in_data   = CT;
        in_valid  = 1'b1;
        tick();
        gap = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid) chk("b2b_pt1", out_data, PT);
            if (in_ready) begin
                gap = n + 1;
                break;
            end
        end
        chk("b2b_gap", 128'(gap), 128'd13);
        tick();
        in_valid = 1'b0;
        m = 0;
        while (!out_valid && m < 40) begin
            tick();
            m++;
        end
        chk("b2b_lat2", 128'(m), 128'd11);
        chk("b2b_pt2", out_data, PT);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 128'(in_ready), 128'd1);

        // Reset mid-ROUND at rnd=5
        in_data  = CT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        chk("mid_rk5", 128'(rk_idx), 128'd5);
        #2;
        rst = 1'b1;
        #2;
        chk("mid_rst_rdy", 128'(in_ready), 128'd0);
        chk("mid_rst_rk", 128'(rk_idx), 128'd0);
        rst = 1'b0;
        #1;
        chk("mid_rel_valid", 128'(out_valid), 128'd0);
        chk("mid_rel_data", out_data, 128'd0);
        chk("mid_rel_rdy", 128'(in_ready), 128'd1);
        tick();
        do_block("post_rst");

`ifdef AES_INV_ABORT_EN
        // Abort in ROUND, then abort in IDLE, then a clean block
        in_data  = CT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_idle", 128'(in_ready), 128'd1);
        chk("abt_valid", 128'(out_valid), 128'd0);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("abt_no_valid", 128'(out_valid), 128'd0);
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("abt_blk_rdy", 128'(in_ready), 128'd0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abt_blk_rk", 128'(rk_idx), 128'd0);
        chk("abt_blk_rdy2", 128'(in_ready), 128'd1);
        do_block("post_abort");
`endif

        do_block("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
